// File: rtl/fu_issue_arbiter_pkg.sv
// Shared definitions for the issue-stage FU arbiter and the FU allocation crossbar.
package fu_issue_arbiter_pkg;

  localparam int N_WAY               = 3;
  localparam int MUL_LATENCY_DEFAULT = 4;

  // One-hot bit positions inside a per-way fu_type field
  localparam int FU_ALU   = 0;
  localparam int FU_MUL   = 1;
  localparam int FU_MEM   = 2;
  localparam int FU_BCOND = 3;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/fu_issue_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr wins; next_ptr points past the winner.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  int   idx;
  logic found;

  // With no request the pointer is returned unchanged, so the caller can register next_ptr blindly
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Issue-stage arbiter: private ALU slots, round-robin shared MUL/MEM/BCOND with occupancy tracking.
// Build option: define MUL_PIPELINED_EN for a fully pipelined MUL (no occupancy counter).
module fu_issue_arbiter #(
  parameter int N_WAY       = fu_issue_arbiter_pkg::N_WAY,
  parameter int MUL_LATENCY = fu_issue_arbiter_pkg::MUL_LATENCY_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_WAY-1:0]     req_valid_in,
  input  logic [4*N_WAY-1:0]   fu_type_in,
  input  logic                 squash_in,
  input  logic                 mem_ready_in,
  input  logic                 mem_done_in,
  output logic [N_WAY-1:0]     grant_out,
  output logic                 mul_busy_out,
  output logic                 mem_busy_out,
  output logic                 illegal_type_out
);

  import fu_issue_arbiter_pkg::*;

  localparam int PW = (N_WAY > 1) ? $clog2(N_WAY) : 1;

  logic [N_WAY-1:0] legal, alu_req, mul_req, mem_req, bcond_req;
  logic [N_WAY-1:0] mul_gnt, mem_gnt, bcond_gnt;
  logic [PW-1:0]    mul_ptr_q, mem_ptr_q, bcond_ptr_q;
  logic [PW-1:0]    mul_ptr_d, mem_ptr_d, bcond_ptr_d;
  logic [3:0]       fu_t;
  logic             issue_en, mul_avail, mem_avail, illegal;
  mem_state_e       mem_state_q, mem_state_d;

  // Reset gating keeps the combinational outputs quiet while reset_n is low
  assign issue_en = reset_n & ~squash_in;

  always_comb begin
    legal     = '0;
    alu_req   = '0;
    mul_req   = '0;
    mem_req   = '0;
    bcond_req = '0;
    illegal   = 1'b0;
    fu_t      = '0;
    for (int i = 0; i < N_WAY; i++) begin
      fu_t         = fu_type_in[4*i +: 4];
      legal[i]     = (fu_t != 4'b0000) && ((fu_t & (fu_t - 4'd1)) == 4'b0000);
      illegal      = illegal | (req_valid_in[i] & ~legal[i]);
      alu_req[i]   = issue_en & req_valid_in[i] & legal[i] & fu_t[FU_ALU];
      mul_req[i]   = issue_en & req_valid_in[i] & legal[i] & fu_t[FU_MUL] & mul_avail;
      mem_req[i]   = issue_en & req_valid_in[i] & legal[i] & fu_t[FU_MEM] & mem_avail;
      bcond_req[i] = issue_en & req_valid_in[i] & legal[i] & fu_t[FU_BCOND];
    end
  end

  assign illegal_type_out = reset_n & illegal;

  rr_pick #(.N(N_WAY), .PW(PW)) u_mul_pick (
    .req(mul_req), .ptr(mul_ptr_q), .gnt(mul_gnt), .next_ptr(mul_ptr_d)
  );

  rr_pick #(.N(N_WAY), .PW(PW)) u_mem_pick (
    .req(mem_req), .ptr(mem_ptr_q), .gnt(mem_gnt), .next_ptr(mem_ptr_d)
  );

  rr_pick #(.N(N_WAY), .PW(PW)) u_bcond_pick (
    .req(bcond_req), .ptr(bcond_ptr_q), .gnt(bcond_gnt), .next_ptr(bcond_ptr_d)
  );

  assign grant_out = alu_req | mul_gnt | mem_gnt | bcond_gnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mul_ptr_q   <= '0;
      mem_ptr_q   <= '0;
      bcond_ptr_q <= '0;
    end else begin
      mul_ptr_q   <= mul_ptr_d;
      mem_ptr_q   <= mem_ptr_d;
      bcond_ptr_q <= bcond_ptr_d;
    end
  end

`ifdef MUL_PIPELINED_EN
  assign mul_avail    = 1'b1;
  assign mul_busy_out = 1'b0;
`else
  logic [3:0] mul_cnt_q;

  // Counter keeps draining under squash since the unit is still busy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mul_cnt_q <= 4'd0;
    end else if (|mul_gnt) begin
      mul_cnt_q <= 4'(MUL_LATENCY - 1);
    end else if (mul_cnt_q != 4'd0) begin
      mul_cnt_q <= mul_cnt_q - 4'd1;
    end
  end

  assign mul_avail    = (mul_cnt_q == 4'd0);
  assign mul_busy_out = (mul_cnt_q != 4'd0);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) mem_state_q <= MEM_IDLE;
    else          mem_state_q <= mem_state_d;
  end

  always_comb begin
    mem_state_d = mem_state_q;
    case (mem_state_q)
      MEM_IDLE: if (|mem_gnt)   mem_state_d = MEM_WAIT;
      MEM_WAIT: if (mem_done_in) mem_state_d = MEM_IDLE;
      default:                   mem_state_d = MEM_IDLE;
    endcase
  end

  assign mem_avail    = (mem_state_q == MEM_IDLE) & mem_ready_in;
  assign mem_busy_out = (mem_state_q == MEM_WAIT);

endmodule

// File: doc/fu_issue_arbiter.md
# fu_issue_arbiter

Issue-stage arbiter for the 3-way core. It sits between the reservation-station select logic and the FU allocation crossbar, and decides each cycle which of the `N_WAY` candidate instructions may go to its functional unit. ALU slots are private to each way. MUL, MEM and BCOND are single shared units: the arbiter grants each to at most one way per cycle, using round-robin fairness. It also tracks MUL occupancy and MEM outstanding state so that grants respect unit availability.

## Interface
Parameters:
- `N_WAY`, 3, issue width; the rotating pointers are sized for it (2 bits at 3).
- `MUL_LATENCY`, 4, MUL occupancy in cycles, including the issue cycle; legal range 1..15.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid_in`  in  `N_WAY`  candidate instruction present on way i.
- `fu_type_in`  in  4*`N_WAY`  per-way one-hot FU type, bit order {bcond, mem, mul, alu}.
- `squash_in`  in  1  flush; suppresses every grant this cycle.
- `mem_ready_in`  in  1  MEM unit can accept an operation.
- `mem_done_in`  in  1  single-cycle pulse; outstanding MEM operation completed.
- `grant_out`  out  `N_WAY`  way i is issued this cycle; the RS frees the entry; this also feeds the crossbar's per-way valid.
- `mul_busy_out`  out  1  MUL occupied (counter nonzero).
- `mem_busy_out`  out  1  MEM FSM is in WAIT.
- `illegal_type_out`  out  1  some valid way has a zero or multi-hot `fu_type`.

## Operation
- **Validity:** a way is eligible only if `req_valid_in[i]` is high and `fu_type_in[i]` is exactly one-hot. A valid way with a zero or multi-hot type is never granted and raises `illegal_type_out` that cycle.
- **ALU:** an eligible alu-type way is granted unconditionally. The grant is suppressed by squash only.
- **Shared FUs (MUL, MEM, BCOND):** each has its own rotating pointer `rr_ptr` in 0..`N_WAY`-1.
  - The winner is the first requesting way at index `rr_ptr`, `rr_ptr`+1, … modulo `N_WAY`.
  - On a grant, `rr_ptr` <= (winner+1) mod `N_WAY`.
  - With no grant, `rr_ptr` holds.
  - Losing ways see `grant_out`=0 and retry next cycle.
- **MUL counter `mul_cnt`:**
  - A grant is allowed only when `mul_cnt`==0.
  - On a grant, the counter loads `MUL_LATENCY`-1; otherwise it decrements while nonzero.
- **MEM FSM:**
  - States: IDLE, WAIT.
  - In IDLE, a grant is allowed only if `mem_ready_in` is high; a grant moves the FSM to WAIT.
  - In WAIT, no MEM grant is made; `mem_done_in` returns the FSM to IDLE.
  - `mem_done_in` seen while in IDLE is ignored.
- **BCOND:** no occupancy; at most one grant per cycle.
- **Squash:**
  - `grant_out` is forced to 0 and all `rr_ptr` values hold.
  - `mul_cnt` keeps decrementing, because in-flight hardware still drains.
  - The MEM FSM stays in WAIT until `mem_done_in`.
- **Reset:** asynchronous assertion at any time clears all state immediately, including mid-MUL and mid-WAIT.

## Timing
- **Grant timing:** `grant_out` is combinational from the inputs and the registered state, valid in the same cycle. There is no added latency.
- **State update:** state updates on the `clock` edge after the grant.
- **MUL back-to-back spacing:** a MUL granted at cycle t allows the next MUL grant at the earliest at t+`MUL_LATENCY`. With `MUL_LATENCY`=1, back-to-back grants are allowed.
- **MEM spacing:** a MEM granted at t puts the FSM in WAIT at t+1. If done arrives at cycle d, the earliest next MEM grant is d+1.
- **Reset values, while `reset_n`=0:**
  - `grant_out`=0, `mul_busy_out`=0, `mem_busy_out`=0, `illegal_type_out`=0.
  - All `rr_ptr`=0, `mul_cnt`=0, MEM FSM=IDLE.

## Configuration
- **`MUL_PIPELINED_EN`:**
  - Defined: MUL is fully pipelined. `mul_cnt` is compiled out, `mul_busy_out` is tied to 0, and one MUL grant is allowed every cycle.
  - Undefined: the occupancy counter behaves as described under Operation.

## Structure
- **Shared package:**
  - FU-type one-hot bit indices (ALU=0, MUL=1, MEM=2, BCOND=3), also used by the crossbar.
  - The MEM FSM state enum.
  - `N_WAY`, `MUL_LATENCY_DEFAULT`.
- **Sub-module `rr_pick`:**
  - Parameterised N-input round-robin picker: request vector plus pointer in, one-hot grant plus next pointer out.
  - Instantiated three times (MUL, MEM, BCOND).

## Test plan
- **Rotation:** all three ways request MUL every cycle, `MUL_LATENCY`=1, no squash. Grants are way0, way1, way2, way0 on consecutive cycles.
- **MUL occupancy:** `MUL_LATENCY`=4, way1 MUL granted at cycle 10, way1 re-requests continuously. `mul_busy_out` is high in cycles 11–13 and the next grant comes at cycle 14; with `MUL_PIPELINED_EN` the next grant comes at 11.
- **MEM handshake:** way2 MEM request with `mem_ready_in`=1 at cycle 5, then `mem_done_in` at cycle 9. Grant at 5, `mem_busy_out` high in 6–9, next grant possible at 10; holding `mem_ready_in`=0 blocks it.
- **Mixed types:** types {alu, alu, bcond} plus a squash cycle. All three ways granted when squash=0; `grant_out`=000 during squash with `rr_ptr` unchanged.
- **Illegal type:** way0 `fu_type`=4'b0110, valid. No grant for way0, `illegal_type_out`=1, ways 1–2 unaffected.
- **Reset mid-operation:** `reset_n` pulsed low while `mul_cnt`=2 and the MEM FSM is in WAIT. Immediately `mul_busy_out`=0 and `mem_busy_out`=0; after release a MUL request is granted to way0.
